// File: rtl/sonar_scheduler.sv
// Round-robin sequencer for several ultrasonic ranging drivers: fires one channel at a time,
// waits for its result or a timeout, then holds off for a guard interval before the next shot.
module sonar_scheduler #(
    parameter int N_CH           = 4,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GUARD_CYCLES   = 3_000_000
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        enable,
    input  logic [N_CH-1:0]                             ch_mask,
    output logic [N_CH-1:0]                             measure,
    input  logic [N_CH-1:0]                             ready,
    input  logic [8*N_CH-1:0]                           distance_in,
    output logic [8*N_CH-1:0]                           dist_out,
    output logic [N_CH-1:0]                             valid,
    output logic [N_CH-1:0]                             timeout,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cur_ch,
    output logic                                        busy,
    output logic                                        round_done
);

    localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int MAXC = (TIMEOUT_CYCLES > GUARD_CYCLES) ? TIMEOUT_CYCLES : GUARD_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
    // Guard counts down to zero and decides on the zero cycle, so the next shot
    // lands GUARD_CYCLES+2 cycles after guard entry.
    localparam logic [TW-1:0] GUARD_LOAD   = TW'(GUARD_CYCLES);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_FIRE   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_GUARD  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cur_ch_q, cur_ch_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [N_CH-1:0]   measure_q, measure_d;
    logic [8*N_CH-1:0] dist_q, dist_d;
    logic [N_CH-1:0]   valid_q, valid_d;
    logic [N_CH-1:0]   timeout_q, timeout_d;
    logic              busy_q, busy_d;
    logic              round_done_q, round_done_d;

    logic              sel_found;
    logic [CW-1:0]     sel_ch;
    logic              more_above;

    // Lowest enabled channel at or above the search pointer; lower indices override higher ones.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            sel_found = sel_found | (ch_mask[i] & (i >= int'(ptr_q)));
            sel_ch    = (ch_mask[i] && (i >= int'(ptr_q))) ? CW'(i) : sel_ch;
        end
    end

    // Whether the mask captured at selection time has any channel left above the current one.
    always_comb begin
        more_above = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            more_above = more_above | (mask_q[i] & (i > int'(cur_ch_q)));
        end
    end

    // Next-state, timer and result-bank logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_ch_d     = cur_ch_q;
        timer_d      = timer_q;
        mask_d       = mask_q;
        measure_d    = '0;
        dist_d       = dist_q;
        valid_d      = valid_q;
        timeout_d    = timeout_q;
        round_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    state_d = S_SELECT;
                    ptr_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SELECT: begin
                mask_d = ch_mask;
                if (sel_found) begin
                    cur_ch_d  = sel_ch;
                    measure_d = N_CH'(1) << sel_ch;
                    state_d   = S_FIRE;
                end else begin
                    round_done_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_FIRE: begin
                timer_d = TIMEOUT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A good result beats an expiring timer in the same cycle.
                if (ready[cur_ch_q]) begin
                    dist_d[int'(cur_ch_q)*8 +: 8] = distance_in[int'(cur_ch_q)*8 +: 8];
                    valid_d[cur_ch_q]   = 1'b1;
                    timeout_d[cur_ch_q] = 1'b0;
                    timer_d             = GUARD_LOAD;
                    state_d             = S_GUARD;
                end else if (timer_q == '0) begin
                    valid_d[cur_ch_q]   = 1'b0;
                    timeout_d[cur_ch_q] = 1'b1;
                    timer_d             = GUARD_LOAD;
                    state_d             = S_GUARD;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            S_GUARD: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (more_above && enable) begin
                    ptr_d   = CW'(cur_ch_q + CW'(1));
                    state_d = S_SELECT;
                end else if (!more_above) begin
                    round_done_d = 1'b1;
                    ptr_d        = '0;
                    state_d      = enable ? S_SELECT : S_IDLE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cur_ch_q     <= '0;
            timer_q      <= '0;
            mask_q       <= '0;
            measure_q    <= '0;
            dist_q       <= '0;
            valid_q      <= '0;
            timeout_q    <= '0;
            busy_q       <= 1'b0;
            round_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_ch_q     <= cur_ch_d;
            timer_q      <= timer_d;
            mask_q       <= mask_d;
            measure_q    <= measure_d;
            dist_q       <= dist_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            round_done_q <= round_done_d;
        end
    end

    assign measure    = measure_q;
    assign dist_out   = dist_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;
    assign cur_ch     = cur_ch_q;
    assign busy       = busy_q;
    assign round_done = round_done_q;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with N_CH=4, TIMEOUT_CYCLES=20, GUARD_CYCLES=5 and
// simple behavioural driver models that answer a programmable number of cycles after measure.
module tb_sonar_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [3:0]  ch_mask;
    logic [3:0]  measure;
    logic [3:0]  ready;
    logic [31:0] distance_in;
    logic [31:0] dist_out;
    logic [3:0]  valid;
    logic [3:0]  timeout;
    logic [1:0]  cur_ch;
    logic        busy;
    logic        round_done;

    logic [3:0]  drv_ready;
    logic [3:0]  stray_ready;
    logic [3:0]  resp_en;
    int          dly [4];
    int          pend [4];
    int          meas_cnt;
    int          rd_cnt;
    int          vectors;
    int          errs;

    assign ready = drv_ready | stray_ready;

    sonar_scheduler #(
        .N_CH           (4),
        .TIMEOUT_CYCLES (20),
        .GUARD_CYCLES   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ch_mask     (ch_mask),
        .measure     (measure),
        .ready       (ready),
        .distance_in (distance_in),
        .dist_out    (dist_out),
        .valid       (valid),
        .timeout     (timeout),
        .cur_ch      (cur_ch),
        .busy        (busy),
        .round_done  (round_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver models: ready pulses dly[i] cycles after the measure cycle when enabled.
    initial begin
        drv_ready = 4'b0000;
        for (int i = 0; i < 4; i++) pend[i] = 0;
        forever begin
            @(negedge clk);
            drv_ready = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (pend[i] > 0) begin
                    pend[i] = pend[i] - 1;
                    if (pend[i] == 0) drv_ready[i] = 1'b1;
                end
                if (measure[i] === 1'b1 && resp_en[i]) pend[i] = dly[i];
            end
        end
    end

    // Counts measure pulse-cycles and round_done cycles.
    initial begin
        meas_cnt = 0;
        rd_cnt   = 0;
        forever begin
            @(negedge clk);
            meas_cnt = meas_cnt + $countones(measure);
            if (round_done === 1'b1) rd_cnt = rd_cnt + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            errs = errs + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_measure"},    32'(measure),    32'h0);
        chk({tag, "_dist"},       dist_out,        32'h0);
        chk({tag, "_valid"},      32'(valid),      32'h0);
        chk({tag, "_timeout"},    32'(timeout),    32'h0);
        chk({tag, "_cur_ch"},     32'(cur_ch),     32'h0);
        chk({tag, "_busy"},       32'(busy),       32'h0);
        chk({tag, "_round_done"}, 32'(round_done), 32'h0);
    endtask

    initial begin
        vectors     = 0;
        errs        = 0;
        rst         = 1'b1;
        enable      = 1'b0;
        ch_mask     = 4'b1111;
        distance_in = 32'h1312_1110;
        resp_en     = 4'b1111;
        stray_ready = 4'b0000;
        for (int i = 0; i < 4; i++) dly[i] = 8;

        tick(3);
        chk_reset_state("reset");

        // Basic round: start latency two cycles, pulses every 16 cycles.
        rst    = 1'b0;
        enable = 1'b1;
        tick(1);
        chk("start_busy", 32'(busy), 32'h1);
        chk("start_no_measure", 32'(measure), 32'h0);
        tick(1);
        chk("fire_ch0", 32'(measure), 32'h1);
        chk("fire_ch0_cur", 32'(cur_ch), 32'h0);
        tick(1);
        chk("pulse_width", 32'(measure), 32'h0);
        tick(15);
        chk("fire_ch1", 32'(measure), 32'h2);
        chk("fire_ch1_cur", 32'(cur_ch), 32'h1);
        tick(16);
        chk("fire_ch2", 32'(measure), 32'h4);
        tick(16);
        chk("fire_ch3", 32'(measure), 32'h8);
        tick(8);
        chk("valid_before_ch3", 32'(valid), 32'h7);
        tick(1);
        chk("round1_dist", dist_out, 32'h1312_1110);
        chk("round1_valid", 32'(valid), 32'hF);
        chk("round1_timeout", 32'(timeout), 32'h0);
        chk("round1_meas_cnt", 32'(meas_cnt), 32'd4);
        chk("round1_rd_early", 32'(rd_cnt), 32'd0);
        distance_in = 32'h2322_2120;
        resp_en     = 4'b1011;
        tick(6);
        chk("round1_done", 32'(round_done), 32'h1);
        tick(1);
        chk("round2_fire_ch0", 32'(measure), 32'h1);
        chk("round1_done_width", 32'(round_done), 32'h0);
        chk("round1_rd_cnt", 32'(rd_cnt), 32'd1);

        // Timeout on ch2, then a stray late ready[2] during ch3's wait.
        tick(32);
        chk("round2_fire_ch2", 32'(measure), 32'h4);
        tick(20);
        chk("to_not_yet", 32'(timeout), 32'h0);
        chk("to_valid_not_yet", 32'(valid), 32'hF);
        tick(1);
        chk("to_flag", 32'(timeout), 32'h4);
        chk("to_valid", 32'(valid), 32'hB);
        chk("to_dist_kept", dist_out, 32'h1312_2120);
        tick(7);
        chk("round2_fire_ch3", 32'(measure), 32'h8);
        chk("round2_cur_ch3", 32'(cur_ch), 32'h3);
        tick(2);
        stray_ready = 4'b0100;
        tick(1);
        stray_ready = 4'b0000;
        chk("stray_valid", 32'(valid), 32'hB);
        chk("stray_timeout", 32'(timeout), 32'h4);
        tick(1);
        chk("stray_ch3_still_waiting", dist_out, 32'h1312_2120);
        tick(5);
        chk("round2_dist", dist_out, 32'h2312_2120);
        chk("round2_valid", 32'(valid), 32'hB);
        chk("round2_timeout", 32'(timeout), 32'h4);
        ch_mask = 4'b1010;

        // Sparse mask: only ch1 and ch3.
        tick(6);
        chk("round2_done", 32'(round_done), 32'h1);
        tick(1);
        chk("sparse_fire_ch1", 32'(measure), 32'h2);
        chk("sparse_cur_ch1", 32'(cur_ch), 32'h1);
        tick(16);
        chk("sparse_fire_ch3", 32'(measure), 32'h8);
        chk("sparse_meas_cnt", 32'(meas_cnt), 32'd9);
        tick(15);
        chk("sparse_done", 32'(round_done), 32'h1);
        tick(1);
        chk("sparse_restart_ch1", 32'(measure), 32'h2);
        chk("sparse_rd_cnt", 32'(rd_cnt), 32'd3);
        chk("sparse_meas_cnt2", 32'(meas_cnt), 32'd10);
        dly[3]      = 20;
        distance_in = 32'h3322_2120;

        // Tie: ch3 answers on its last wait cycle.
        tick(16);
        chk("tie_fire_ch3", 32'(measure), 32'h8);
        tick(20);
        chk("tie_busy", 32'(busy), 32'h1);
        tick(1);
        chk("tie_valid", 32'(valid), 32'hB);
        chk("tie_timeout", 32'(timeout), 32'h4);
        chk("tie_dist", dist_out, 32'h3312_2120);
        ch_mask = 4'b1111;
        dly[3]  = 8;

        // Enable dropped during ch1 wait.
        tick(6);
        chk("tie_round_done", 32'(round_done), 32'h1);
        tick(1);
        chk("en_fire_ch0", 32'(measure), 32'h1);
        tick(16);
        chk("en_fire_ch1", 32'(measure), 32'h2);
        tick(4);
        enable      = 1'b0;
        distance_in = 32'h3322_4120;
        tick(5);
        chk("en_ch1_dist", dist_out, 32'h3312_4120);
        tick(5);
        chk("en_guard_busy", 32'(busy), 32'h1);
        tick(1);
        chk("en_idle_busy", 32'(busy), 32'h0);
        chk("en_idle_measure", 32'(measure), 32'h0);
        chk("en_idle_round_done", 32'(round_done), 32'h0);
        tick(10);
        chk("en_no_ch2", 32'(meas_cnt), 32'd14);
        chk("en_no_round_done", 32'(rd_cnt), 32'd4);
        chk("en_stay_idle", 32'(busy), 32'h0);

        // Reset in the middle of a wait.
        enable = 1'b1;
        tick(2);
        chk("rst_pre_fire_ch0", 32'(measure), 32'h1);
        tick(3);
        rst = 1'b1;
        tick(1);
        chk_reset_state("midrst");
        rst = 1'b0;
        tick(1);
        chk("post_rst_select", 32'(measure), 32'h0);
        tick(1);
        chk("post_rst_fire_ch0", 32'(measure), 32'h1);
        chk("post_rst_cur_ch", 32'(cur_ch), 32'h0);

        enable = 1'b0;
        tick(40);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
